// File: rtl/bandai2003_pkg.sv
// Shared constants and types for the Bandai 2003 cartridge host.
//   Unlock address bytes, mapper register addresses, reply frame geometry,
//   and the host FSM state type.
package bandai2003_pkg;

  localparam logic [7:0] ADDR_UNLK_A = 8'h5A;  // first unlock byte
  localparam logic [7:0] ADDR_UNLK_B = 8'hA5;  // second unlock byte, reply follows
  localparam logic [7:0] ADDR_IDLE   = 8'hFF;  // parked bus value

  // LAO registers
  localparam logic [7:0] REG_C0 = 8'hC0;
  localparam logic [7:0] REG_C1 = 8'hC1;
  localparam logic [7:0] REG_C2 = 8'hC2;
  localparam logic [7:0] REG_C3 = 8'hC3;
  // bank registers
  localparam logic [7:0] REG_D0 = 8'hD0;
  localparam logic [7:0] REG_D1 = 8'hD1;
  localparam logic [7:0] REG_D2 = 8'hD2;
  localparam logic [7:0] REG_D3 = 8'hD3;
  localparam logic [7:0] REG_D4 = 8'hD4;
  localparam logic [7:0] REG_D5 = 8'hD5;

  localparam int          FRAME_W     = 18;       // start + 16 payload + stop
  localparam logic [15:0] DEF_PAYLOAD = 16'h28A0;

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_NAK, S_RX, S_CHECK,
    S_READY, S_SETUP, S_STROBE, S_HOLD, S_ERR
  } state_t;

endpackage

// File: rtl/bandai2003_so_rx.sv
// Serial reply capture for the unlock handshake.
//   CLK, RST   : clock, synchronous active-high reset
//   arm        : high for every cycle SO must be sampled
//   SO         : cartridge serial out, LSB first
//   done       : high on the cycle whose edge captures the final bit
//   pass       : frame check on the held shift register (start=0, stop=0, payload match)
//   payload    : bits [16:1] of the held frame
module bandai2003_so_rx
  import bandai2003_pkg::*;
#(
  parameter logic [15:0] EXP_PAYLOAD = DEF_PAYLOAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        arm,
  input  logic        SO,
  output logic        done,
  output logic        pass,
  output logic [15:0] payload
);

  logic [FRAME_W-1:0] sr;
  logic [4:0]         cnt;

  assign done = arm && (cnt == 5'(FRAME_W - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr  <= '0;
      cnt <= '0;
    end else if (arm) begin
      // shift in from the top so the first bit received ends in sr[0]
      sr <= {SO, sr[FRAME_W-1:1]};
      if (!done) cnt <= cnt + 5'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign payload = sr[16:1];
  assign pass    = !sr[0] && !sr[FRAME_W-1] && (sr[16:1] == EXP_PAYLOAD);

endmodule

// File: rtl/bandai2003_host.sv
// Console-side initiator for the Bandai 2003 mapper.
//   CLK, RST        : clock, synchronous active-high reset
//   start           : begin unlock (accepted in IDLE or ERR)
//   busy, unlocked, lock_err, payload : status
//   SO              : reply stream from the cartridge
//   ADDR, CEn, SSn, WEn, OEn, dq_o, dq_oe, dq_i : cartridge bus
//   req, req_we, req_addr, req_wdata : register access request (READY only)
//   ack, rdata      : access completion and read data
module bandai2003_host
  import bandai2003_pkg::*;
#(
  parameter int          STROBE_CYC  = 2,
  parameter int          RETRIES     = 2,
  parameter logic [15:0] EXP_PAYLOAD = DEF_PAYLOAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        busy,
  output logic        unlocked,
  output logic        lock_err,
  output logic [15:0] payload,
  input  logic        SO,
  output logic [7:0]  ADDR,
  output logic        CEn,
  output logic        SSn,
  output logic        WEn,
  output logic        OEn,
  output logic [7:0]  dq_o,
  output logic        dq_oe,
  input  logic [7:0]  dq_i,
  input  logic        req,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata
);

  state_t      state, nxt;
  logic [2:0]  retry_cnt;
  logic [3:0]  strb_cnt;
  logic        we_q;
  logic [7:0]  addr_q, wdata_q;
  logic        rx_done, rx_pass;
  logic [15:0] rx_payload;
  logic        retry_left, strb_last, bus_cyc;

  bandai2003_so_rx #(.EXP_PAYLOAD(EXP_PAYLOAD)) u_rx (
    .CLK     (CLK),
    .RST     (RST),
    .arm     (state == S_RX),
    .SO      (SO),
    .done    (rx_done),
    .pass    (rx_pass),
    .payload (rx_payload)
  );

  // counters climb to their limit and stop, so equality tests are enough
  assign retry_left = (retry_cnt != 3'(RETRIES));
  assign strb_last  = (strb_cnt == 4'(STROBE_CYC - 1));
  assign bus_cyc    = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_ERR: if (start) nxt = S_ACK;
      S_ACK:         nxt = S_NAK;
      S_NAK:         nxt = S_RX;
      S_RX:          if (rx_done) nxt = S_CHECK;
      S_CHECK:       nxt = rx_pass ? S_READY : (retry_left ? S_ACK : S_ERR);
      S_READY:       if (req) nxt = S_SETUP;
      S_SETUP:       nxt = S_STROBE;
      S_STROBE:      if (strb_last) nxt = S_HOLD;
      S_HOLD:        nxt = S_READY;
      default:       nxt = S_IDLE;
    endcase
  end

  // bus pins decoded straight from state; all return to idle with state
  always_comb begin
    busy  = !((state == S_IDLE) || (state == S_READY) || (state == S_ERR));
    ADDR  = ADDR_IDLE;
    if (state == S_ACK)      ADDR = ADDR_UNLK_A;
    else if (state == S_NAK) ADDR = ADDR_UNLK_B;
    else if (bus_cyc)        ADDR = addr_q;
    CEn   = 1'b1;                  // register space is reached through SSn only
    SSn   = !bus_cyc;
    WEn   = !((state == S_STROBE) && we_q);
    OEn   = !((state == S_STROBE) && !we_q);
    dq_oe = bus_cyc && we_q;       // never overlaps a read strobe
    dq_o  = dq_oe ? wdata_q : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      retry_cnt <= '0;
      strb_cnt  <= '0;
      we_q      <= 1'b0;
      addr_q    <= ADDR_IDLE;
      wdata_q   <= '0;
      unlocked  <= 1'b0;
      lock_err  <= 1'b0;
      payload   <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      unique case (state)
        S_IDLE, S_ERR: if (start) begin
          retry_cnt <= '0;
          lock_err  <= 1'b0;
        end
        S_CHECK: begin
          payload <= rx_payload;
          if (rx_pass)         unlocked  <= 1'b1;
          else if (retry_left) retry_cnt <= retry_cnt + 3'd1;
          else                 lock_err  <= 1'b1;
        end
        S_READY: if (req) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
        S_SETUP: strb_cnt <= '0;
        S_STROBE: begin
          if (strb_last) begin
            if (!we_q) rdata <= dq_i;
          end else begin
            strb_cnt <= strb_cnt + 4'd1;
          end
        end
        S_HOLD: ack <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bandai2003_host.sv
module tb_bandai2003_host;
  import bandai2003_pkg::*;

  logic        CLK = 1'b0, RST = 1'b1, start = 1'b0;
  logic        busy, unlocked, lock_err, ack;
  logic [15:0] payload;
  logic        SO;
  logic [7:0]  ADDR, dq_o, dq_i, rdata;
  logic        CEn, SSn, WEn, OEn, dq_oe;
  logic        req = 1'b0, req_we = 1'b0;
  logic [7:0]  req_addr = 8'h00, req_wdata = 8'h00;

  int errors = 0, checks = 0;

  bandai2003_host dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .unlocked(unlocked),
    .lock_err(lock_err), .payload(payload), .SO(SO), .ADDR(ADDR), .CEn(CEn),
    .SSn(SSn), .WEn(WEn), .OEn(OEn), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata)
  );

  always #5 CLK = ~CLK;

  // cartridge model: reply frame starts the cycle after A5h is seen
  logic        so_stuck = 1'b0, bad_first = 1'b0;
  logic        active = 1'b0, wen_d = 1'b1;
  logic [4:0]  bit_i = '0;
  logic [17:0] frame = '1;
  int          att = 0, ack_seen = 0, nak_seen = 0;
  logic [8:0]  bank1 = '0;

  always @(posedge CLK) begin
    if (ADDR == ADDR_UNLK_A) ack_seen <= ack_seen + 1;
    if (ADDR == ADDR_UNLK_B) begin
      nak_seen <= nak_seen + 1;
      frame    <= {1'b0, (bad_first && att == 0) ? 16'h28A1 : 16'h28A0, 1'b0};
      att      <= att + 1;
      active   <= 1'b1;
      bit_i    <= '0;
    end else if (active) begin
      bit_i <= bit_i + 5'd1;
      if (bit_i == 5'd17) active <= 1'b0;
    end
    wen_d <= WEn;
    if (!wen_d && WEn && !SSn && dq_oe && ADDR == REG_C2) bank1 <= {1'b0, dq_o};
  end

  assign SO   = (so_stuck || !active) ? 1'b1 : frame[bit_i];
  assign dq_i = !OEn ? ((ADDR == REG_D3) ? 8'h02 : 8'h00) : 8'h00;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!unlocked && !lock_err && n < 300) begin tick(); n++; end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bus"}, {ADDR, CEn, SSn, WEn, OEn, dq_oe, dq_o},
        {8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
    chk({tag, "_stat"}, {busy, ack, unlocked, lock_err, payload, rdata},
        {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00});
  endtask

  initial begin
    do_reset();
    chk_idle("reset");

    // unlock timing
    pulse_start();
    chk("ack_addr", ADDR, 8'h5A);
    chk("ack_busy", busy, 1'b1);
    tick(); chk("nak_addr", ADDR, 8'hA5);
    tick(); chk("rx_addr", ADDR, 8'hFF);       // edge E
    repeat (18) tick();
    chk("check_cycle_unl", unlocked, 1'b0);
    chk("check_cycle_busy", busy, 1'b1);
    tick();                                      // E+19
    chk("unlocked", unlocked, 1'b1);
    chk("payload", payload, 16'h28A0);
    chk("ready_busy", busy, 1'b0);

    // write C2h <= 37h
    req = 1'b1; req_we = 1'b1; req_addr = REG_C2; req_wdata = 8'h37;
    tick(); req = 1'b0;
    chk("wr_setup", {ADDR, SSn, CEn, WEn, dq_oe, dq_o}, {8'hC2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h37});
    tick(); chk("wr_strobe0", {WEn, OEn}, 2'b01);
    tick(); chk("wr_strobe1", {WEn, OEn}, 2'b01);
    tick(); chk("wr_hold", {WEn, SSn, dq_oe, ADDR}, {1'b1, 1'b0, 1'b1, 8'hC2});
    tick();
    chk("wr_ack", {ack, SSn, dq_oe, ADDR}, {1'b1, 1'b1, 1'b0, 8'hFF});
    chk("wr_model", bank1, 9'h037);
    tick(); chk("wr_ack_pulse", ack, 1'b0);

    // read D3h
    req = 1'b1; req_we = 1'b0; req_addr = REG_D3;
    tick(); req = 1'b0;
    chk("rd_setup", {ADDR, SSn, OEn, dq_oe}, {8'hD3, 1'b0, 1'b1, 1'b0});
    tick(); chk("rd_strobe0", {OEn, WEn, dq_oe}, 3'b010);
    tick(); chk("rd_strobe1", {OEn, WEn, dq_oe}, 3'b010);
    tick(); chk("rd_hold", {OEn, dq_oe}, 2'b10);
    tick(); chk("rd_ack", {ack, rdata}, {1'b1, 8'h02});
    tick(); chk("rd_hold_data", {ack, rdata}, {1'b0, 8'h02});

    // start ignored in READY
    pulse_start();
    chk("ready_start_ign", {busy, ADDR}, {1'b0, 8'hFF});

    // absent cart: three attempts then ERR
    do_reset();
    so_stuck = 1'b1; ack_seen = 0; nak_seen = 0;
    pulse_start();
    wait_done("stuck_to");
    chk("stuck_pairs", {ack_seen[7:0], nak_seen[7:0]}, 16'h0303);
    chk("stuck_flags", {lock_err, unlocked, busy}, 3'b100);
    chk("stuck_payload", payload, 16'hFFFF);

    // restart from ERR, first reply corrupt, second good
    so_stuck = 1'b0; bad_first = 1'b1; att = 0; ack_seen = 0; nak_seen = 0;
    pulse_start();
    chk("err_restart_clr", {lock_err, busy}, 2'b01);
    wait_done("retry_to");
    chk("retry_pairs", nak_seen, 2);
    chk("retry_flags", {unlocked, lock_err}, 2'b10);
    chk("retry_payload", payload, 16'h28A0);
    bad_first = 1'b0;

    // reset during RX
    do_reset();
    pulse_start(); tick(); tick();
    repeat (5) tick();
    RST = 1'b1; tick();
    chk_idle("rst_rx");
    RST = 1'b0;
    pulse_start();
    wait_done("rst_rx_to");
    chk("rst_rx_unl", {unlocked, payload}, {1'b1, 16'h28A0});

    // reset during STROBE
    req = 1'b1; req_we = 1'b1; req_addr = REG_C2; req_wdata = 8'h55;
    tick(); req = 1'b0;
    tick();
    chk("mid_strobe", WEn, 1'b0);
    RST = 1'b1; tick();
    chk_idle("rst_strobe");
    RST = 1'b0;
    tick();
    chk("no_late_write", bank1, 9'h037);
    pulse_start();
    wait_done("rst_st_to");
    chk("rst_st_unl", {unlocked, lock_err, payload}, {1'b1, 1'b0, 16'h28A0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bandai2003_host.md
Name: bandai2003_host

Overview:
Console-side initiator for the Bandai 2003 cartridge mapper. It drives the two-step address unlock sequence, then receives and checks the 18-bit synchronous reply stream on SO. Once unlocked, it runs register read/write bus cycles into the mapper's LAO and bank registers. It sits between the system-control logic and the cartridge bus pins.

Parameters:
STROBE_CYC, 2, cycles WEn/OEn held low per bus access (1..15)
RETRIES, 2, extra unlock attempts after a failed reply check (0..7)
EXP_PAYLOAD, 16'h28A0, expected reply payload

Ports:
CLK  in  1  system clock; cartridge mapper clocked from the same edge
RST  in  1  synchronous reset, active-high
start  in  1  pulse: begin unlock; ignored unless state IDLE or ERR
busy  out  1  high in any state except IDLE, READY, ERR
unlocked  out  1  reply matched; held until RST
lock_err  out  1  all attempts failed; cleared by next accepted start
payload  out  16  last received payload bits
SO  in  1  cartridge serial out; undriven reads as 1 (pull-up)
ADDR  out  8  cartridge ADDR bus
CEn  out  1  chip enable, active-low
SSn  out  1  system select, active-low
WEn  out  1  write strobe, active-low
OEn  out  1  output enable, active-low
dq_o  out  8  DQ drive value
dq_oe  out  1  DQ drive enable; pad tri-states when low
dq_i  in  8  DQ pad input
req  in  1  bus request; accepted only in READY
req_we  in  1  1 = write, 0 = read
req_addr  in  8  mapper register address (C0h..D5h)
req_wdata  in  8  write data
ack  out  1  one-cycle pulse when an access completes
rdata  out  8  read data, valid with ack and held afterwards

Behaviour:
- Reset values: ADDR=FFh; CEn=SSn=WEn=OEn=1; dq_oe=0; dq_o=00h; busy=ack=unlocked=lock_err=0; payload=0000h; rdata=00h; retry counter=0.
- States: IDLE, ACK, NAK, RX, CHECK, READY, SETUP, STROBE, HOLD, ERR.
- IDLE/ERR + start -> ACK. The retry counter is cleared and lock_err is cleared.
- ACK: drive ADDR=5Ah for exactly one cycle -> NAK.
- NAK: drive ADDR=A5h for exactly one cycle (call the edge that leaves NAK edge E) -> RX. ADDR returns to FFh.
- RX: sample SO on edges E+1 .. E+18, LSB first, into an 18-bit shift register -> CHECK.
- CHECK (1 cycle): pass when bit0=0, bit17=0 and bits[16:1]=EXP_PAYLOAD. payload <= bits[16:1] on both pass and fail.
  - Pass -> READY, unlocked=1.
  - Fail with retries left -> retry counter +1, then ACK.
  - Fail with no retries left -> ERR, lock_err=1.
- An all-ones stream (cart absent or already locked out) fails the start-bit check.
- READY + req -> SETUP; all req_* inputs are latched. In READY and ERR, a start pulse is ignored (READY) or restarts unlock (ERR).
- SETUP (1 cycle): ADDR=req_addr, SSn=0, CEn=1. Write: dq_o=wdata, dq_oe=1.
- STROBE (STROBE_CYC cycles): WEn=0 (write) or OEn=0 (read). Read: rdata <= dq_i on the last STROBE cycle.
- HOLD (1 cycle): WEn=OEn=1 while ADDR, SSn and dq still held. This rising strobe is the mapper's latch point.
- Leaving HOLD: ack=1 for one cycle, dq_oe=0, SSn=1, ADDR=FFh -> READY.
- req asserted during SETUP, STROBE or HOLD is ignored; there is no queue.
- WEn and OEn are never low together. dq_oe=0 whenever OEn=0.
- RST mid-operation: all outputs return to reset values on the next edge, including a partially received stream. The strobe is not completed.
- The strobe counter is 4 bits and the retry counter is 3 bits; neither wraps.

Decomposition:
- Shared package bandai2003_pkg:
  - unlock address constants 5Ah, A5h, FFh
  - register address constants C0h..C3h and D0h..D5h
  - reply frame width 18 and default payload 28A0h
  - state enum type
- One sub-module: bandai2003_so_rx, an 18-bit serial capture plus frame check. Inputs: arm, SO. Outputs: done, pass, payload.

Test Plan:
- Cart model replies {0,28A0h,0} after A5h; start -> ADDR 5Ah then A5h on consecutive cycles, CHECK at E+19, unlocked=1, payload=28A0h, busy=0.
- SO stuck at 1, RETRIES=2 -> exactly 3 ACK/NAK pairs, then lock_err=1, unlocked=0, payload=FFFFh.
- After unlock, write C2h<=37h -> SSn=0, dq_o=37h, WEn low for 2 cycles, rising in HOLD; model bank1=037h; ack one pulse.
- Read D3h with model returning 02h -> OEn low for 2 cycles, dq_oe=0 throughout, rdata=02h with ack.
- Corrupt payload (28A1h) on the first attempt, good on the second -> one retry, then unlocked=1.
- RST asserted during RX and during STROBE -> all outputs at reset values next cycle; a fresh start unlocks normally.
